// File: rtl/dummy_accelerator_issue_cu.sv
// Core-side issue control unit for the dummy accelerator: registered request stage,
// in-order tag FIFO and registered writeback stage, with flush discarding all in-flight state.
module dummy_accelerator_issue_cu #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTL_W  = 8,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [CTL_W-1:0]           issue_ctl_i,
    input  logic [DATA_W-1:0]          issue_data_i,
    input  logic [TAG_W-1:0]           issue_tag_i,
    output logic                       acc_valid_o,
    input  logic                       acc_ready_i,
    output logic [CTL_W-1:0]           acc_ctl_o,
    output logic [DATA_W-1:0]          acc_data_o,
    output logic                       acc_flush_o,
    input  logic                       acc_res_valid_i,
    output logic                       acc_res_ready_o,
    input  logic [DATA_W-1:0]          acc_res_data_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [TAG_W-1:0]           wb_tag_o,
    output logic [DATA_W-1:0]          wb_data_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic REQ_EMPTY = 1'b0;
    localparam logic REQ_FULL  = 1'b1;
    localparam logic OUT_EMPTY = 1'b0;
    localparam logic OUT_FULL  = 1'b1;

    logic              req_state_q, req_state_d;
    logic [CTL_W-1:0]  req_ctl_q, req_ctl_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;

    logic [TAG_W-1:0]  tag_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              out_state_q, out_state_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic fifo_full, fifo_empty;
    logic issue_fire, acc_fire, res_fire, wb_fire;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Readiness uses the count at cycle start; a same-cycle pop does not free a slot.
    assign issue_ready_o   = !flush_i && ((req_state_q == REQ_EMPTY) || acc_ready_i) && !fifo_full;
    assign acc_res_ready_o = !flush_i && !fifo_empty && ((out_state_q == OUT_EMPTY) || wb_ready_i);

    assign issue_fire = issue_valid_i && issue_ready_o;
    assign acc_fire   = acc_valid_o && acc_ready_i;
    assign res_fire   = acc_res_valid_i && acc_res_ready_o;
    assign wb_fire    = wb_valid_o && wb_ready_i;

    assign acc_valid_o   = (req_state_q == REQ_FULL);
    assign acc_ctl_o     = req_ctl_q;
    assign acc_data_o    = req_data_q;
    assign acc_flush_o   = flush_i;
    assign wb_valid_o    = (out_state_q == OUT_FULL);
    assign wb_tag_o      = out_tag_q;
    assign wb_data_o     = out_data_q;
    assign outstanding_o = count_q;

    always_comb begin
        req_state_d = req_state_q;
        req_ctl_d   = req_ctl_q;
        req_data_d  = req_data_q;
        if (issue_fire) begin
            req_state_d = REQ_FULL;
            req_ctl_d   = issue_ctl_i;
            req_data_d  = issue_data_i;
        end else if (acc_fire) begin
            req_state_d = REQ_EMPTY;
        end
        if (flush_i) begin
            req_state_d = REQ_EMPTY;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (res_fire)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({issue_fire, res_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;
        if (res_fire) begin
            out_state_d = OUT_FULL;
            out_tag_d   = tag_mem_q[rd_ptr_q];
            out_data_d  = acc_res_data_i;
        end else if (wb_fire) begin
            out_state_d = OUT_EMPTY;
        end
        if (flush_i) begin
            out_state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_state_q <= REQ_EMPTY;
            req_ctl_q   <= '0;
            req_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_state_q <= OUT_EMPTY;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else begin
            req_state_q <= req_state_d;
            req_ctl_q   <= req_ctl_d;
            req_data_q  <= req_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_state_q <= out_state_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (issue_fire) begin
            tag_mem_q[wr_ptr_q] <= issue_tag_i;
        end
    end

endmodule

// File: tb/tb_dummy_accelerator_issue_cu.sv
// Directed bench for dummy_accelerator_issue_cu; expected accelerator requests and writebacks
// are queued by the stimulus and consumed by a monitor on each observed handshake.
module tb_dummy_accelerator_issue_cu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [7:0]  issue_ctl_i;
    logic [63:0] issue_data_i;
    logic [3:0]  issue_tag_i;
    logic        acc_valid_o;
    logic        acc_ready_i;
    logic [7:0]  acc_ctl_o;
    logic [63:0] acc_data_o;
    logic        acc_flush_o;
    logic        acc_res_valid_i;
    logic        acc_res_ready_o;
    logic [63:0] acc_res_data_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [3:0]  wb_tag_o;
    logic [63:0] wb_data_o;
    logic [2:0]  outstanding_o;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [63:0] data;
    } acc_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] data;
    } wb_t;

    acc_t exp_acc[$];
    wb_t  exp_wb[$];
    int   checks   = 0;
    int   failures = 0;

    dummy_accelerator_issue_cu #(
        .DATA_W(64),
        .CTL_W (8),
        .TAG_W (4),
        .DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_ctl_i    (issue_ctl_i),
        .issue_data_i   (issue_data_i),
        .issue_tag_i    (issue_tag_i),
        .acc_valid_o    (acc_valid_o),
        .acc_ready_i    (acc_ready_i),
        .acc_ctl_o      (acc_ctl_o),
        .acc_data_o     (acc_data_o),
        .acc_flush_o    (acc_flush_o),
        .acc_res_valid_i(acc_res_valid_i),
        .acc_res_ready_o(acc_res_ready_o),
        .acc_res_data_i (acc_res_data_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_tag_o       (wb_tag_o),
        .wb_data_o      (wb_data_o),
        .outstanding_o  (outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes are sampled on the falling edge, between input updates.
    always @(negedge clk) begin
        if (!rst_i && !flush_i) begin
            if (acc_valid_o && acc_ready_i) begin
                if (exp_acc.size() == 0) begin
                    chk("acc_unexpected_fire", acc_valid_o, 1'b0);
                end else begin
                    acc_t e;
                    e = exp_acc.pop_front();
                    chk("acc_ctl", acc_ctl_o, e.ctl);
                    chk("acc_data", acc_data_o, e.data);
                end
            end
            if (wb_valid_o && wb_ready_i) begin
                if (exp_wb.size() == 0) begin
                    chk("wb_unexpected_fire", wb_valid_o, 1'b0);
                end else begin
                    wb_t w;
                    w = exp_wb.pop_front();
                    chk("wb_tag", wb_tag_o, w.tag);
                    chk("wb_data", wb_data_o, w.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves issue_valid_i high on return; the caller drops it.
    task automatic do_issue(input logic [7:0] c, input logic [63:0] d, input logic [3:0] t);
        int n;
        issue_valid_i = 1'b1;
        issue_ctl_i   = c;
        issue_data_i  = d;
        issue_tag_i   = t;
        n = 0;
        @(negedge clk);
        while (!issue_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!issue_ready_o) chk("issue_timeout", issue_ready_o, 1'b1);
        else exp_acc.push_back('{ctl: c, data: d});
        step();
    endtask

    task automatic do_result(input logic [63:0] d, input logic [3:0] t);
        int n;
        acc_res_valid_i = 1'b1;
        acc_res_data_i  = d;
        n = 0;
        @(negedge clk);
        while (!acc_res_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!acc_res_ready_o) chk("result_timeout", acc_res_ready_o, 1'b1);
        else exp_wb.push_back('{tag: t, data: d});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        issue_valid_i = 1'b0; issue_ctl_i = '0; issue_data_i = '0; issue_tag_i = '0;
        acc_ready_i = 1'b0; acc_res_valid_i = 1'b0; acc_res_data_i = '0; wb_ready_i = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_acc_valid", acc_valid_o, 1'b0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_acc_data", acc_data_o, 0);
        chk("rst_wb_tag", wb_tag_o, 0);
        step();
        rst_i = 1'b0;

        // Single issue and result round trip.
        acc_ready_i = 1'b1; wb_ready_i = 1'b1;
        issue_valid_i = 1'b1; issue_ctl_i = 8'd3; issue_data_i = 64'h55; issue_tag_i = 4'd2;
        @(negedge clk);
        chk("t1_issue_ready", issue_ready_o, 1'b1);
        chk("t1_acc_valid_before", acc_valid_o, 1'b0);
        chk("t1_outstanding0", outstanding_o, 0);
        exp_acc.push_back('{ctl: 8'd3, data: 64'h55});
        step();
        issue_valid_i = 1'b0;
        @(negedge clk);
        chk("t1_acc_valid_after", acc_valid_o, 1'b1);
        chk("t1_outstanding1", outstanding_o, 1);
        step();
        acc_res_valid_i = 1'b1; acc_res_data_i = 64'hAA;
        @(negedge clk);
        chk("t1_res_ready", acc_res_ready_o, 1'b1);
        chk("t1_wb_valid_before", wb_valid_o, 1'b0);
        exp_wb.push_back('{tag: 4'd2, data: 64'hAA});
        step();
        acc_res_valid_i = 1'b0;
        @(negedge clk);
        chk("t1_wb_valid", wb_valid_o, 1'b1);
        chk("t1_outstanding_end", outstanding_o, 0);
        step();
        @(negedge clk);
        chk("t1_wb_valid_drop", wb_valid_o, 1'b0);
        step();

        // Fill the tag FIFO, then drain in order.
        for (int i = 1; i <= 4; i++) do_issue(8'(i), 64'(i * 17), 4'(i));
        @(negedge clk);
        chk("t2_outstanding_full", outstanding_o, 4);
        chk("t2_fifth_ready", issue_ready_o, 1'b0);
        step();
        issue_valid_i = 1'b0;
        do_result(64'h10, 4'd1);
        do_result(64'h20, 4'd2);
        do_result(64'h30, 4'd3);
        do_result(64'h40, 4'd4);
        acc_res_valid_i = 1'b0;
        repeat (2) step();
        chk("t2_outstanding_drained", outstanding_o, 0);
        chk("t2_acc_queue_drained", exp_acc.size(), 0);
        chk("t2_wb_queue_drained", exp_wb.size(), 0);

        // Accelerator backpressure holds the request register.
        acc_ready_i = 1'b0;
        do_issue(8'd7, 64'h77, 4'd5);
        issue_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", acc_valid_o, 1'b1);
            chk("t3_hold_ctl", acc_ctl_o, 8'd7);
            chk("t3_hold_data", acc_data_o, 64'h77);
            chk("t3_issue_blocked", issue_ready_o, 1'b0);
            step();
        end
        acc_ready_i = 1'b1;
        step();
        @(negedge clk);
        chk("t3_single_fire", acc_valid_o, 1'b0);
        step();

        // Writeback backpressure, then back-to-back writebacks.
        wb_ready_i = 1'b0;
        do_result(64'h500, 4'd5);
        acc_res_valid_i = 1'b0;
        do_issue(8'd1, 64'h66, 4'd6);
        do_issue(8'd2, 64'h67, 4'd7);
        issue_valid_i = 1'b0;
        acc_res_valid_i = 1'b1; acc_res_data_i = 64'h600;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_res_blocked", acc_res_ready_o, 1'b0);
            chk("t4_hold_valid", wb_valid_o, 1'b1);
            chk("t4_hold_tag", wb_tag_o, 4'd5);
            chk("t4_hold_data", wb_data_o, 64'h500);
            step();
        end
        wb_ready_i = 1'b1;
        @(negedge clk);
        chk("t4_res_ready_b2b", acc_res_ready_o, 1'b1);
        exp_wb.push_back('{tag: 4'd6, data: 64'h600});
        step();
        acc_res_data_i = 64'h700;
        @(negedge clk);
        chk("t4_res_ready_second", acc_res_ready_o, 1'b1);
        chk("t4_no_bubble1", wb_valid_o, 1'b1);
        exp_wb.push_back('{tag: 4'd7, data: 64'h700});
        step();
        acc_res_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_no_bubble2", wb_valid_o, 1'b1);
        step();
        @(negedge clk);
        chk("t4_wb_idle", wb_valid_o, 1'b0);
        chk("t4_outstanding", outstanding_o, 0);
        step();

        // Result with no outstanding tag is refused.
        acc_res_valid_i = 1'b1; acc_res_data_i = 64'h999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_res_refused", acc_res_ready_o, 1'b0);
            chk("t5_wb_quiet", wb_valid_o, 1'b0);
            step();
        end
        acc_res_valid_i = 1'b0;
        chk("t5_acc_queue_drained", exp_acc.size(), 0);
        chk("t5_wb_queue_drained", exp_wb.size(), 0);

        // Flush with simultaneous issue and result.
        wb_ready_i = 1'b0;
        for (int i = 8; i <= 11; i++) do_issue(8'(i), 64'(i * 16), 4'(i));
        issue_valid_i = 1'b0;
        do_result(64'h800, 4'd8);
        issue_valid_i = 1'b1; issue_ctl_i = 8'd12; issue_data_i = 64'hC; issue_tag_i = 4'd12;
        acc_res_valid_i = 1'b1; acc_res_data_i = 64'h900;
        flush_i = 1'b1;
        @(negedge clk);
        chk("t6_pre_outstanding", outstanding_o, 3);
        chk("t6_pre_wb_valid", wb_valid_o, 1'b1);
        chk("t6_acc_flush", acc_flush_o, 1'b1);
        chk("t6_issue_ready_flush", issue_ready_o, 1'b0);
        chk("t6_res_ready_flush", acc_res_ready_o, 1'b0);
        step();
        flush_i = 1'b0; issue_valid_i = 1'b0; acc_res_valid_i = 1'b0;
        exp_acc.delete();
        exp_wb.delete();
        @(negedge clk);
        chk("t6_post_outstanding", outstanding_o, 0);
        chk("t6_post_acc_valid", acc_valid_o, 1'b0);
        chk("t6_post_wb_valid", wb_valid_o, 1'b0);
        chk("t6_post_acc_flush", acc_flush_o, 1'b0);
        step();

        // Asynchronous reset in the middle of traffic.
        acc_ready_i = 1'b0;
        do_issue(8'd9, 64'hDD, 4'd13);
        issue_valid_i = 1'b0;
        do_result(64'hDDD, 4'd13);
        acc_res_valid_i = 1'b0;
        @(negedge clk);
        chk("t7_busy_acc_valid", acc_valid_o, 1'b1);
        chk("t7_busy_wb_valid", wb_valid_o, 1'b1);
        #2;
        exp_acc.delete();
        exp_wb.delete();
        rst_i = 1'b1;
        #1;
        chk("t7_rst_acc_valid", acc_valid_o, 1'b0);
        chk("t7_rst_wb_valid", wb_valid_o, 1'b0);
        chk("t7_rst_outstanding", outstanding_o, 0);
        chk("t7_rst_acc_ctl", acc_ctl_o, 0);
        chk("t7_rst_acc_data", acc_data_o, 0);
        chk("t7_rst_wb_tag", wb_tag_o, 0);
        chk("t7_rst_wb_data", wb_data_o, 0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
